// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 keyboard receiver for the memory-mapped register at
//               0xF000. Synchronizes the PS/2 clock/data pins, deframes
//               11-bit device-to-host frames and queues scancodes in a FIFO.
//               The head is presented combinationally on data_out and is
//               popped by ren.
// Options     : PS2_PARITY_CHECK_EN - when defined, frames with bad (even)
//               parity are dropped; otherwise only the stop bit gates a push.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ren,
  output logic [15:0] data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_ONE   = WW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [3:0]    CNT_STOP = 4'd10;
  localparam logic [3:0]    CNT_PAR  = 4'd9;

  // --------------------------------------------------------------------------
  // Pin synchronization and falling-edge detection
  // --------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       fall;
  logic       bit_in;

  // Two-flop synchronizers for both pins plus one edge-detect register; idle
  // PS/2 lines are high so everything resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // --------------------------------------------------------------------------
  // Frame receiver FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [WW-1:0] wd;
  logic          push;
  logic [7:0]    push_byte;
  logic          frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  // Stop bit must be 1 and data plus parity must carry an odd ones-count.
  assign frame_ok = bit_in & (^{parity_bit, shreg});
`else
  logic parity_unused;
  // Parity is sampled on the wire but does not influence acceptance.
  assign parity_unused = 1'b0;
  assign frame_ok      = bit_in;
`endif

  // Deframer: start bit opens a frame, data bits shift in LSB first, the
  // accept decision is registered on the stop bit so the FIFO write strobe
  // is high for exactly the CHECK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      wd         <= '0;
      push       <= 1'b0;
      push_byte  <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      case (state)
        IDLE: begin
          wd <= '0;
          if (fall && !bit_in) begin
            state   <= SHIFT;
            bit_cnt <= 4'd1;
          end else begin
            bit_cnt <= 4'd0;
          end
        end

        SHIFT: begin
          if (fall) begin
            wd <= '0;
            if (bit_cnt == CNT_STOP) begin
              state     <= CHECK;
              push      <= frame_ok;
              push_byte <= shreg;
              bit_cnt   <= 4'd0;
            end else begin
              if (bit_cnt == CNT_PAR) begin
`ifdef PS2_PARITY_CHECK_EN
                parity_bit <= bit_in;
`endif
              end else begin
                shreg <= {bit_in, shreg[7:1]};
              end
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (wd == WD_LAST) begin
            // Device went quiet mid-frame: discard what was collected.
            state   <= IDLE;
            wd      <= '0;
            bit_cnt <= 4'd0;
          end else begin
            wd <= wd + WD_ONE;
          end
        end

        CHECK: begin
          state <= IDLE;
          wd    <= '0;
        end

        default: begin
          state   <= IDLE;
          wd      <= '0;
          bit_cnt <= 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scancode FIFO
  // --------------------------------------------------------------------------
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] head;
  logic [AW:0] tail;
  logic        ovf;
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;
  logic        ovf_set;

  assign empty   = (head == tail);
  assign full    = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
  // A pop at empty is ignored, so a simultaneous push simply writes.
  assign do_pop  = ren & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  // Pointer and overflow-sticky update; set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      ovf  <= 1'b0;
    end else begin
      if (do_pop) begin
        head <= head + PTR_ONE;
      end
      if (do_push) begin
        tail <= tail + PTR_ONE;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ren) begin
        ovf <= 1'b0;
      end
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail[AW-1:0]] <= push_byte;
    end
  end

  assign data_out = {~empty, ovf, 6'b000000,
                     empty ? 8'h00 : mem[head[AW-1:0]]};

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx
// Description : Self-checking bench for ps2_rx. Drives PS/2 frames, keeps a
//               scoreboard queue of the scancodes the FIFO should hold and
//               compares data_out against it as entries are popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int HALF  = 8;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic        ren      = 1'b0;
  logic [15:0] data_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];
  logic       ovf_m = 1'b0;

  ps2_rx #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ren     (ren),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word();
    if (sb.size() == 0) return {1'b0, ovf_m, 14'h0000};
    return {1'b1, ovf_m, 6'h00, sb[0]};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard update for a completed frame.
  task automatic model_push(input logic [7:0] b, input bit valid);
    if (valid) begin
      if (sb.size() < DEPTH) sb.push_back(b);
      else ovf_m = 1'b1;
    end
  endtask

  // Drive the first nbits of a frame; optionally pulse ren in the CHECK cycle.
  task automatic send_bits(input logic [7:0] b, input logic par, input logic stp,
                           input int nbits, input bit ren_at_check);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clks(HALF / 2);
      ps2_clk = 1'b0;
      if (ren_at_check && i == 10) begin
        // fall seen after 2 sync edges, sampled at the 3rd, CHECK during the 4th
        wait_clks(3);
        ren = 1'b1;
        wait_clks(1);
        ren = 1'b0;
        wait_clks(HALF - 4);
      end else begin
        wait_clks(HALF);
      end
      ps2_clk = 1'b1;
      wait_clks(HALF / 2);
    end
    ps2_data = 1'b1;
    wait_clks(4);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good_par, input logic stp);
    logic par;
    par = good_par ? ~(^b) : (^b);
    send_bits(b, par, stp, 11, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    check_eq(tag, data_out, model_word());
    ren = 1'b1;
    wait_clks(1);
    ren = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
    ovf_m = 1'b0;
  endtask

  initial begin
    wait_clks(3);
    check_eq("reset", data_out, 16'h0000);
    rst_n = 1'b1;
    wait_clks(2);

    // Basic frame and pop
    send_frame(8'h1C, 1'b1, 1'b1);
    model_push(8'h1C, 1'b1);
    check_eq("frame_1c", data_out, 16'h801C);
    pop_check("pop_1c");
    check_eq("after_pop", data_out, 16'h0000);

    // Wrong parity
    send_frame(8'h1C, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    model_push(8'h1C, 1'b0);
    check_eq("bad_parity", data_out, 16'h0000);
`else
    model_push(8'h1C, 1'b1);
    check_eq("bad_parity", data_out, 16'h801C);
    pop_check("pop_bad_parity");
`endif
    check_eq("bad_parity_empty", data_out, 16'h0000);

    // Bad stop bit is always dropped
    send_frame(8'h33, 1'b1, 1'b0);
    model_push(8'h33, 1'b0);
    check_eq("bad_stop", data_out, 16'h0000);

    // Overflow: nine frames, no pops
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      model_push(8'(i), 1'b1);
    end
    check_eq("ovf_head", data_out, 16'hC001);
    pop_check("drain_ovf_0");
    check_eq("second_read", data_out, 16'h8002);
    for (int i = 1; i < 8; i++) pop_check($sformatf("drain_ovf_%0d", i));
    check_eq("ovf_drained", data_out, 16'h0000);

    // Full FIFO with pop in the CHECK cycle of a new frame
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
      model_push(8'h10 + 8'(i), 1'b1);
    end
    check_eq("full_head", data_out, 16'h8010);
    send_bits(8'h18, ~(^8'h18), 1'b1, 11, 1'b1);
    void'(sb.pop_front());
    sb.push_back(8'h18);
    ovf_m = 1'b0;
    check_eq("full_push_pop", data_out, 16'h8011);
    for (int i = 0; i < 8; i++) pop_check($sformatf("drain_full_%0d", i));
    check_eq("full_drained", data_out, 16'h0000);

    // Watchdog discards a partial frame
    send_bits(8'hA5, ~(^8'hA5), 1'b1, 5, 1'b0);
    wait_clks(TMO + 5);
    send_frame(8'hF0, 1'b1, 1'b1);
    model_push(8'hF0, 1'b1);
    check_eq("timeout_f0", data_out, 16'h80F0);
    pop_check("pop_f0");
    check_eq("timeout_single", data_out, 16'h0000);

    // Reset mid-frame with entries queued
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h21 + 8'(i), 1'b1, 1'b1);
      model_push(8'h21 + 8'(i), 1'b1);
    end
    check_eq("pre_reset", data_out, 16'h8021);
    send_bits(8'h77, ~(^8'h77), 1'b1, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("reset_async", data_out, 16'h0000);
    wait_clks(2);
    rst_n = 1'b1;
    sb.delete();
    ovf_m = 1'b0;
    wait_clks(2);
    send_frame(8'h5A, 1'b1, 1'b1);
    model_push(8'h5A, 1'b1);
    check_eq("after_reset_5a", data_out, 16'h805A);
    pop_check("pop_5a");
    check_eq("final_empty", data_out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
